// File: rtl/mul_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : mul_secuencial
//  Description : Sequential shift-add multiplier. It has one WIDTH-bit adder
//                row and performs one iteration per cycle, so a WIDTH x WIDTH
//                product takes WIDTH cycles. Operation is controlled by a
//                start/busy/done handshake. The 2*WIDTH-bit product is
//                registered and held until the next operation completes.
//                Macro MUL_SIGNED_EN : when defined, X, Y and P are two's
//                complement (arithmetic shift, last partial product
//                subtracted). When undefined, only the unsigned datapath is
//                built.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_secuencial #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Reject meaningless widths at elaboration time
    generate
        if (WIDTH < 2) begin : g_width_check
            $error("mul_secuencial: WIDTH must be at least 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_m;      // multiplicand, frozen for the operation
    logic [WIDTH-1:0]     r_q;      // multiplier, shifted out as product LSBs
    logic [WIDTH:0]       r_a;      // accumulator, one guard bit wide
    logic [c_CNT_W-1:0]   r_cnt;    // iteration index
    logic [2*WIDTH-1:0]   r_p;      // product held for the consumer

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [1:0]           w_state_nxt;
    logic                 w_accept;
    logic                 w_calc;
    logic                 w_last;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic                 w_fill;
    logic [WIDTH:0]       w_a_shift;
    logic [WIDTH-1:0]     w_q_shift;

    // A start is accepted whenever no multiplication is in flight. This
    // includes the DONE cycle, so back-to-back operations need no idle gap.
    assign w_calc   = (r_state == c_CALC);
    assign w_accept = start && !w_calc;
    assign w_last   = (r_cnt == c_CNT_LAST);

    // One iteration: conditionally add the multiplicand, then shift {A,Q} right
    always_comb begin
        w_addend = {1'b0, r_m};
        w_sum    = r_a;
        w_fill   = 1'b0;
`ifdef MUL_SIGNED_EN
        // The multiplier MSB has weight -2^(N-1), so the last partial
        // product is subtracted. The shift replicates the accumulator sign.
        w_addend = {r_m[WIDTH-1], r_m};
        if (r_q[0]) begin
            if (w_last) begin
                w_sum = r_a - w_addend;
            end else begin
                w_sum = r_a + w_addend;
            end
        end
        w_fill   = w_sum[WIDTH];
`else
        // The guard bit absorbs the carry, so the sum never overflows
        if (r_q[0]) begin
            w_sum = r_a + w_addend;
        end
`endif
        w_a_shift = {w_fill, w_sum[WIDTH:1]};
        w_q_shift = {w_sum[0], r_q[WIDTH-1:1]};
    end

    // Next-state decode for the IDLE -> CALC -> DONE sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_CALC;
                end
            end
            c_CALC: begin
                if (w_last) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = start ? c_CALC : c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Control state register. Async reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture on acceptance, then one shift-add step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= '0;
            r_q   <= '0;
            r_a   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_m   <= X;
            r_q   <= Y;
            r_a   <= '0;
            r_cnt <= '0;
        end else if (w_calc) begin
            r_a   <= w_a_shift;
            r_q   <= w_q_shift;
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // The product register loads only on the last step, which is the entry
    // into DONE. It holds through IDLE and through the next CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p <= '0;
        end else if (w_calc && w_last) begin
            r_p <= {w_a_shift[WIDTH-1:0], w_q_shift};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy = w_calc;
    assign done = (r_state == c_DONE);
    assign P    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mul_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_secuencial
//  Description : Scoreboard bench for mul_secuencial at WIDTH=4 and WIDTH=8.
//                It checks handshake timing, abort on reset, ignored starts,
//                back-to-back operation and a random sweep. Signed cases are
//                added when MUL_SIGNED_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_secuencial;

    logic        clk;
    logic        rst;
    logic        start4, start8;
    logic [3:0]  x4, y4;
    logic [7:0]  x8, y8;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [15:0] p;
        int          acc;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];

    mul_secuencial #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .X(x4), .Y(y4),
        .busy(busy4), .done(done4), .P(p4)
    );

    mul_secuencial #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .X(x8), .Y(y8),
        .busy(busy8), .done(done8), .P(p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
`ifdef MUL_SIGNED_EN
        ea = {{8{a[7]}}, a};
        eb = {{8{b[7]}}, b};
`else
        ea = {8'd0, a};
        eb = {8'd0, b};
`endif
        return ea * eb;
    endfunction

    // Drive a one-cycle start. The caller is at posedge+1 and the DUT is free.
    task automatic drive4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
        exp_t e;
        start4 = 1'b1; x4 = x; y4 = y;
        e.p = {8'd0, exp};
        e.acc = cyc + 1;
        sb4.push_back(e);
        @(posedge clk); #1;
        start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
    endtask

    task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        exp_t e;
        start8 = 1'b1; x8 = x; y8 = y;
        e.p = exp;
        e.acc = cyc + 1;
        sb8.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: each done pulse pops one expected product and its latency
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (sb4.size() == 0) begin
                check_eq("done4_unexpected", done4, 1'b0);
            end else begin
                e = sb4.pop_front();
                check_eq("P4", p4, e.p);
                check_eq("lat4", cyc - e.acc, 4);
            end
        end
        if (done8) begin
            if (sb8.size() == 0) begin
                check_eq("done8_unexpected", done8, 1'b0);
            end else begin
                e = sb8.pop_front();
                check_eq("P8", p8, e.p);
                check_eq("lat8", cyc - e.acc, 8);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] ra, rb;
        rst = 1'b1; start4 = 0; start8 = 0; x4 = 0; y4 = 0; x8 = 0; y8 = 0;
        #1;
        check_eq("rst_busy4", busy4, 0);
        check_eq("rst_done4", done4, 0);
        check_eq("rst_P4", p4, 0);
        check_eq("rst_P8", p8, 0);
        step(2);
        rst = 1'b0;
        step(1);

        // 15 x 15: busy for 4 cycles, done on the 5th cycle, product held afterwards
`ifdef MUL_SIGNED_EN
        drive4(4'd15, 4'd15, 8'h01);
`else
        drive4(4'd15, 4'd15, 8'hE1);
`endif
        for (int i = 0; i < 4; i++) begin
            check_eq("busy4_calc", busy4, 1);
            check_eq("done4_calc", done4, 0);
            step(1);
        end
        check_eq("busy4_done", busy4, 0);
        check_eq("done4_pulse", done4, 1);
        step(1);
        check_eq("done4_single", done4, 0);
`ifdef MUL_SIGNED_EN
        check_eq("P4_hold", p4, 8'h01);
`else
        check_eq("P4_hold", p4, 8'hE1);
`endif
        step(2);

        // 0 x 9, then 9 x 1 accepted back-to-back in the DONE cycle
        drive4(4'd0, 4'd9, 8'h00);
        step(4);
        check_eq("b2b_done", done4, 1);
`ifdef MUL_SIGNED_EN
        drive4(4'd9, 4'd1, 8'hF9);
`else
        drive4(4'd9, 4'd1, 8'h09);
`endif
        check_eq("b2b_busy", busy4, 1);
        step(6);

        // 6 x 7, with a start while busy that must be ignored
        drive4(4'd6, 4'd7, 8'd42);
        step(1);
        start4 = 1'b1; x4 = 4'd3; y4 = 4'd3;
        step(1);
        start4 = 1'b0;
        step(6);
        check_eq("P4_after_ignored", p4, 8'd42);

        // 5 x 5 aborted by an async reset in the middle of the operation
        drive4(4'd5, 4'd5, 8'd25);
        step(1);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_busy4", busy4, 0);
        check_eq("abort_done4", done4, 0);
        check_eq("abort_P4", p4, 0);
        sb4.delete();
        #1 rst = 1'b0;
        step(8);
        check_eq("abort_P4_hold", p4, 0);
        drive4(4'd2, 4'd3, 8'd6);
        step(6);

`ifdef MUL_SIGNED_EN
        drive4(4'h8, 4'h8, 8'h40);
        step(4);
        drive4(4'h8, 4'h7, 8'hC8);
        step(4);
        drive4(4'h7, 4'hF, 8'hF9);
        step(6);
`endif

        // WIDTH=8: all-ones operands, then a back-to-back random sweep
        drive8(8'hFF, 8'hFF, ref8(8'hFF, 8'hFF));
        step(8);
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            drive8(ra, rb, ref8(ra, rb));
            step(8);
        end

        // Drain both scoreboards with a bounded wait
        t = 0;
        while ((sb4.size() != 0 || sb8.size() != 0) && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        check_eq("drain4", sb4.size(), 0);
        check_eq("drain8", sb8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
